// File: rtl/uart_pkg.sv
// Shared types and the round-robin search used by the uart TX arbiter.
// rr_pick is also meant for a future uart RX dispatch block.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} arb_state_t;

  localparam int UART_DATA_W = 8;
  localparam int MAX_REQ     = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t   res;
    logic [3:0] cand;
    res = '0;
    // Walk from the far end so the candidate nearest ptr+1 is the one kept.
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        cand = {1'b0, ptr} + 4'(i);
        if (cand >= 4'(n)) cand = cand - 4'(n);
        if (valid[cand[2:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority search starting at ptr+1.
module rr_select
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), 3'(ptr), NUM_REQ);
    found = pick.found;
    idx   = PTR_W'(pick.idx);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart transmitter among NUM_REQ byte requesters,
// with a watchdog for a transmitter that never raises tx_busy.
//
// state     | meaning
// IDLE      | waiting for a request while the uart is idle
// ISSUE     | uart_data_en high, waiting for tx_busy to rise
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_W        = UART_DATA_W,
  parameter  int START_TIMEOUT = 16,
  localparam int GID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         uart_data_in,
  output logic                      uart_data_en,
  input  logic                      uart_tx_busy,
  output logic [GID_W-1:0]          grant_id,
  output logic                      active,
  output logic                      timeout_err,
  input  logic                      err_clr
);

  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  arb_state_t       state;
  logic [GID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_found;
  logic [GID_W-1:0] pick_idx;
  logic             grant;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Gated by rstn so a reset edge never doubles as an accept edge.
  assign grant = rstn && (state == IDLE) && !uart_tx_busy && pick_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      rr_ptr       <= GID_W'(NUM_REQ - 1);
      cnt          <= '0;
      uart_data_in <= '0;
      uart_data_en <= 1'b0;
      grant_id     <= '0;
      active       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            uart_data_in <= req_data[pick_idx*DATA_W +: DATA_W];
            grant_id     <= pick_idx;
            rr_ptr       <= pick_idx;
            uart_data_en <= 1'b1;
            active       <= 1'b1;
            cnt          <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (uart_tx_busy) begin
            uart_data_en <= 1'b0;
            state        <= WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            timeout_err  <= 1'b1;
            uart_data_en <= 1'b0;
            active       <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: loopback uart model, transaction-level arbiter
// model checked every cycle, directed scenarios and a randomized soak.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   uart_data_in;
  logic           uart_data_en;
  logic           uart_tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic           timeout_err;
  logic           err_clr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .START_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_data_in (uart_data_in),
    .uart_data_en (uart_data_en),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .active       (active),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loopback uart: starts a frame 0..3 cycles after data_en, busy for 1..6 cycles.
  bit         uart_stuck = 1'b0;
  bit         uart_force = 1'b0;
  int         frame_left = 0, wait_cnt = 0, start_dly = 0, frame_len = 3;
  logic [7:0] rx_q[$];

  initial forever begin
    @(posedge clk); #2;
    if (frame_left > 0) frame_left--;
    else if (!uart_stuck && !uart_force && uart_data_en) begin
      if (wait_cnt >= start_dly) begin
        frame_left = frame_len;
        rx_q.push_back(uart_data_in);
        wait_cnt  = 0;
        start_dly = $urandom_range(0, 3);
        frame_len = $urandom_range(1, 6);
      end else wait_cnt++;
    end else wait_cnt = 0;
    uart_tx_busy = (frame_left > 0) || uart_force;
  end

  // Transaction-level model: a byte is either absent, offered (waiting for
  // the uart to start) or being sent.
  bit         m_fl = 0, m_st = 0, m_err = 0;
  int         m_en_cycles = 0, m_ptr = N - 1, m_gid = 0;
  logic [7:0] m_data = '0;
  bit         chk_on = 0;
  logic [N-1:0] last_ready = '0;
  int         dut_grants[$];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    begin : model_step
      int           g;
      logic [N-1:0] exp_rdy;
      bit           tmo;
      g = -1; exp_rdy = '0; tmo = 0;
      if (!m_fl && !uart_tx_busy && rstn) g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
      last_ready = req_ready;
      if (chk_on) begin
        chk("req_ready",    int'(req_ready),    int'(exp_rdy));
        chk("uart_data_en", int'(uart_data_en), int'(m_fl && !m_st));
        chk("uart_data_in", int'(uart_data_in), int'(m_data));
        chk("grant_id",     int'(grant_id),     m_gid);
        chk("active",       int'(active),       int'(m_fl));
        chk("timeout_err",  int'(timeout_err),  int'(m_err));
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
      end
      if (!rstn) begin
        m_fl = 0; m_st = 0; m_en_cycles = 0; m_ptr = N - 1;
        m_gid = 0; m_data = '0; m_err = 0;
      end else begin
        if (!m_fl) begin
          if (g >= 0) begin
            m_fl = 1; m_st = 0; m_en_cycles = 1;
            m_gid = g; m_ptr = g; m_data = req_data[g*W +: W];
          end
        end else if (!m_st) begin
          if (uart_tx_busy) m_st = 1;
          else if (m_en_cycles == TO) begin m_fl = 0; tmo = 1; end
          else m_en_cycles++;
        end else if (!uart_tx_busy) m_fl = 0;
        if (tmo) m_err = 1;
        else if (err_clr) m_err = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_quiet(input string name, input int max);
    int k = 0;
    while ((active || uart_tx_busy) && k < max) begin step(1); k++; end
    chk(name, int'(active || uart_tx_busy), 0);
  endtask

  task automatic wait_grants(input string name, input int n, input int max);
    int k = 0;
    while (dut_grants.size() < n && k < max) begin step(1); k++; end
    chk(name, int'(dut_grants.size() >= n), 1);
  endtask

  function automatic int gv(input int i);
    return (dut_grants.size() > i) ? dut_grants[i] : -1;
  endfunction

  function automatic int rxv(input int i);
    return (rx_q.size() > i) ? int'(rx_q[i]) : -1;
  endfunction

  task automatic pulse_reset();
    rstn = 1'b0; step(1); rstn = 1'b1;
    rx_q.delete(); dut_grants.delete();
  endtask

  initial begin
    int cnt;
    int exp3[7] = '{0, 3, 0, 3, 0, 1, 3};
    int exp2g[5] = '{0, 1, 2, 3, 0};

    step(1); chk_on = 1; step(1);
    chk("rst_active",   int'(active), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_data_en",  int'(uart_data_en), 0);
    chk("rst_data_in",  int'(uart_data_in), 0);
    chk("rst_err",      int'(timeout_err), 0);
    rstn = 1'b1;

    // Single requester
    req_data[2*W +: W] = 8'hA5; req_valid = 4'b0100; #1;
    chk("t1_ready", int'(req_ready), 4);
    step(1); req_valid = '0;
    chk("t1_grant_id", int'(grant_id), 2);
    chk("t1_data_en",  int'(uart_data_en), 1);
    chk("t1_data_in",  int'(uart_data_in), 8'hA5);
    wait_quiet("t1_quiet", 60);
    chk("t1_rx_cnt", rx_q.size(), 1);
    chk("t1_rx",     rxv(0), 8'hA5);

    // All requesting after reset
    pulse_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_valid = 4'b1111;
    wait_grants("t2_wait", 5, 300); req_valid = '0;
    wait_quiet("t2_quiet", 60);
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", gv(i), exp2g[i]);
      chk("t2_rx", rxv(i), 8'h10 + exp2g[i]);
    end

    // Fairness with skipped requesters, requester 1 joins mid-frame
    pulse_reset();
    req_valid = 4'b0001; wait_grants("t3_w1", 1, 60);
    req_valid = 4'b1001; wait_grants("t3_w4", 4, 300);
    req_valid = 4'b1011; wait_grants("t3_w7", 7, 300);
    req_valid = '0; wait_quiet("t3_quiet", 60);
    for (int i = 0; i < 7; i++) chk("t3_order", gv(i), exp3[i]);

    // Start timeout, clear, then clear colliding with a new timeout
    uart_stuck = 1'b1;
    req_valid = 4'b0001; step(1); req_valid = '0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (uart_data_en) cnt++;
      if (!active) break;
      step(1);
    end
    chk("t4_en_cycles", cnt, 16);
    chk("t4_err_set",   int'(timeout_err), 1);
    chk("t4_idle",      int'(active), 0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("t4_err_clr", int'(timeout_err), 0);
    err_clr = 1'b1; req_valid = 4'b0001; step(1); req_valid = '0;
    for (int k = 0; k < 40 && active; k++) step(1);
    chk("t4_set_wins", int'(timeout_err), 1);
    step(1);
    chk("t4_clr_after", int'(timeout_err), 0);
    err_clr = 1'b0; uart_stuck = 1'b0;

    // Reset during WAIT_DONE
    req_valid = 4'b0010; step(1); req_valid = '0;
    for (int k = 0; k < 40 && !(active && !uart_data_en); k++) step(1);
    chk("t5_in_wait", int'(active && !uart_data_en), 1);
    rstn = 1'b0; step(1); rstn = 1'b1;
    chk("t5_active",   int'(active), 0);
    chk("t5_grant_id", int'(grant_id), 0);
    chk("t5_data_en",  int'(uart_data_en), 0);
    chk("t5_data_in",  int'(uart_data_in), 0);
    dut_grants.delete(); req_valid = 4'b1010;
    wait_grants("t5_wait", 1, 60); req_valid = '0;
    chk("t5_next_grant", gv(0), 1);
    wait_quiet("t5_quiet", 60);

    // Foreign busy while idle
    uart_force = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t6_no_ready", int'(req_ready), 0);
    end
    uart_force = 1'b0; #2;
    chk("t6_ready", int'(req_ready), 1);
    step(1); req_valid = '0;
    wait_quiet("t6_quiet", 60);

    // Randomized soak
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) uart_stuck = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_ready[i] && rstn) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else req_data[i*W +: W] = 8'($urandom);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = 8'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      err_clr = ($urandom_range(0, 7) == 0);
      rstn    = ($urandom_range(0, 299) != 0);
      step(1);
    end
    req_valid = '0; rstn = 1'b1; err_clr = 1'b0; uart_stuck = 1'b0;
    wait_quiet("t7_quiet", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
